uart_tx_arbiter: RTL

Shares one UartTx instance between NUM_REQUESTERS byte producers using round-robin arbitration.
- Accepts bytes over a per-requester valid/ready handshake.
- Issues a single-cycle write pulse to the transmitter, which ignores a held-high write, so every write must be a fresh pulse.
- Holds data and line configuration stable for the whole packet.
- Tracks completion via the transmitter's busy output.
- Sits between the host-side byte sources and the UartTx serial datapath.

---
 rtl/uart_pkg.sv | 22 ++
 rtl/uart_rr_picker.sv | 28 ++
 rtl/uart_tx_arbiter.sv | 132 +++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared state encoding and sizing helpers for the UART transmit arbiter
package uart_pkg;

    localparam logic [1:0] ST_IDLE      = 2'd0;
    localparam logic [1:0] ST_ISSUE     = 2'd1;
    localparam logic [1:0] ST_WAIT_BUSY = 2'd2;
    localparam logic [1:0] ST_WAIT_DONE = 2'd3;

    localparam int DEFAULT_DIV_W = 16;

    typedef enum logic [1:0] {
        IDLE      = ST_IDLE,
        ISSUE     = ST_ISSUE,
        WAIT_BUSY = ST_WAIT_BUSY,
        WAIT_DONE = ST_WAIT_DONE
    } state_t;

    function automatic int id_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/uart_rr_picker.sv
// uart_rr_picker: combinational round-robin winner search starting after the last grant
module uart_rr_picker
    import uart_pkg::*;
#(
    parameter int NUM_REQUESTERS = 4,
    parameter int ID_W           = id_width(NUM_REQUESTERS)
) (
    input  logic [NUM_REQUESTERS-1:0] i_valid,
    input  logic [ID_W-1:0]           i_last,
    output logic [ID_W-1:0]           o_winner,
    output logic                      o_any
);

    logic [ID_W-1:0] w_idx;

    assign o_any = |i_valid;

    // Walk offsets from farthest to nearest so the nearest valid index after i_last wins.
    always_comb begin
        o_winner = '0;
        w_idx    = '0;
        for (int k = NUM_REQUESTERS; k >= 1; k--) begin
            w_idx    = ID_W'((int'(i_last) + k) % NUM_REQUESTERS);
            o_winner = i_valid[w_idx] ? w_idx : o_winner;
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin sharing of one UartTx between several byte producers,
// issuing single-cycle write pulses and tracking packet completion through tx_busy_i.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int NUM_REQUESTERS      = 4,
    parameter int CLOCK_DIVIDER_WIDTH = DEFAULT_DIV_W,
    parameter int BUSY_TIMEOUT        = 4
) (
    input  logic                                 clock_i,
    input  logic                                 reset_i,
    input  logic [NUM_REQUESTERS-1:0]            req_valid_i,
    input  logic [8*NUM_REQUESTERS-1:0]          req_data_i,
    output logic [NUM_REQUESTERS-1:0]            req_ready_o,
    input  logic                                 cfg_two_stop_bits_i,
    input  logic                                 cfg_parity_bit_i,
    input  logic                                 cfg_parity_even_i,
    input  logic [CLOCK_DIVIDER_WIDTH-1:0]       cfg_clock_divider_i,
    output logic                                 tx_write_o,
    output logic [7:0]                           tx_data_o,
    output logic                                 tx_two_stop_bits_o,
    output logic                                 tx_parity_bit_o,
    output logic                                 tx_parity_even_o,
    output logic [CLOCK_DIVIDER_WIDTH-1:0]       tx_clock_divider_o,
    input  logic                                 tx_busy_i,
    output logic [id_width(NUM_REQUESTERS)-1:0]  grant_id_o,
    output logic                                 done_o,
    output logic                                 error_o
);

    localparam int ID_W  = id_width(NUM_REQUESTERS);
    localparam int CNT_W = id_width(BUSY_TIMEOUT + 1);

    state_t                         r_state;
    logic [ID_W-1:0]                r_last;
    logic [CNT_W-1:0]               r_cnt;
    logic                           r_write;
    logic [7:0]                     r_data;
    logic                           r_two_stop;
    logic                           r_parity;
    logic                           r_parity_even;
    logic [CLOCK_DIVIDER_WIDTH-1:0] r_div;
    logic [ID_W-1:0]                r_grant_id;
    logic                           r_done;
    logic                           r_error;

    logic [ID_W-1:0]                w_winner;
    logic                           w_any;
    logic                           w_grant;

    uart_rr_picker #(
        .NUM_REQUESTERS (NUM_REQUESTERS),
        .ID_W           (ID_W)
    ) u_picker (
        .i_valid  (req_valid_i),
        .i_last   (r_last),
        .o_winner (w_winner),
        .o_any    (w_any)
    );

    // Ready is only offered while idle and the transmitter is free, never during reset.
    assign w_grant     = (r_state == IDLE) && !tx_busy_i && w_any && !reset_i;
    assign req_ready_o = w_grant ? (NUM_REQUESTERS'(1) << w_winner) : '0;

    assign tx_write_o         = r_write;
    assign tx_data_o          = r_data;
    assign tx_two_stop_bits_o = r_two_stop;
    assign tx_parity_bit_o    = r_parity;
    assign tx_parity_even_o   = r_parity_even;
    assign tx_clock_divider_o = r_div;
    assign grant_id_o         = r_grant_id;
    assign done_o             = r_done;
    assign error_o            = r_error;

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            r_state       <= IDLE;
            r_last        <= ID_W'(NUM_REQUESTERS - 1);
            r_cnt         <= '0;
            r_write       <= 1'b0;
            r_data        <= '0;
            r_two_stop    <= 1'b0;
            r_parity      <= 1'b0;
            r_parity_even <= 1'b0;
            r_div         <= '0;
            r_grant_id    <= '0;
            r_done        <= 1'b0;
            r_error       <= 1'b0;
        end else begin
            r_write <= 1'b0;
            r_done  <= 1'b0;
            r_error <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_grant) begin
                        r_data        <= req_data_i[{w_winner, 3'b000} +: 8];
                        r_two_stop    <= cfg_two_stop_bits_i;
                        r_parity      <= cfg_parity_bit_i;
                        r_parity_even <= cfg_parity_even_i;
                        r_div         <= cfg_clock_divider_i;
                        r_grant_id    <= w_winner;
                        r_last        <= w_winner;
                        r_write       <= 1'b1;
                        r_state       <= ISSUE;
                    end
                end
                ISSUE: begin
                    r_cnt   <= '0;
                    r_state <= WAIT_BUSY;
                end
                WAIT_BUSY: begin
                    if (tx_busy_i) begin
                        r_state <= WAIT_DONE;
                    end else if (r_cnt == CNT_W'(BUSY_TIMEOUT - 1)) begin
                        r_error <= 1'b1;
                        r_state <= IDLE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                WAIT_DONE: begin
                    if (!tx_busy_i) begin
                        r_done  <= 1'b1;
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule
